// File: rtl/pe_vec_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_vec_if
// Description : Micro-op and result bundle between the operand broadcast
//               logic and the pe_vec lanes.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_vec_if #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int SHW   = $clog2(2*DW+8)
);
    logic [LANES*DW-1:0] x;
    logic [LANES*DW-1:0] weight;
    logic                in_valid;
    logic                flush;
    logic                out_en;
    logic                calc_bias;
    logic                relu_en;
    logic [SHW-1:0]      shift;
    logic [LANES*DW-1:0] result_r;
    logic                out_valid_r;
    logic [LANES-1:0]    sat_r;
    logic                illegal_uop;

    modport master (
        output x, weight, in_valid, flush, out_en, calc_bias, relu_en, shift,
        input  result_r, out_valid_r, sat_r, illegal_uop
    );

    modport slave (
        input  x, weight, in_valid, flush, out_en, calc_bias, relu_en, shift,
        output result_r, out_valid_r, sat_r, illegal_uop
    );
endinterface
`default_nettype wire

// File: rtl/pe_vec.sv
`default_nettype none
// ============================================================================
// Module      : pe_vec
// Description : LANES signed MAC lanes sharing one micro-op stream; two-stage
//               accumulate with shift / ReLU / saturating requantisation.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_vec #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int ACC_W = 2*DW+8,
    parameter int SHW   = $clog2(ACC_W)
) (
    input  wire      clk,
    input  wire      rst_n,
    pe_vec_if.slave  bus
);
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic                w_illegal;
    logic                w_emit;
    logic                r_s1_valid;
    logic                r_s1_flush;
    logic                r_s1_out;
    logic                r_s1_relu;
    logic [SHW-1:0]      r_s1_shift;
    logic [LANES*DW-1:0] w_res;
    logic [LANES-1:0]    w_sat;

    // Dropped combos never reach S1, so they cannot disturb the accumulators.
    assign w_illegal = (bus.flush & (bus.in_valid | bus.calc_bias | bus.out_en))
                     | (~bus.in_valid & (bus.calc_bias | bus.out_en));
    assign w_emit    = r_s1_valid & r_s1_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid      <= 1'b0;
            r_s1_flush      <= 1'b0;
            r_s1_out        <= 1'b0;
            r_s1_relu       <= 1'b0;
            r_s1_shift      <= '0;
            bus.illegal_uop <= 1'b0;
            bus.out_valid_r <= 1'b0;
            bus.result_r    <= '0;
            bus.sat_r       <= '0;
        end else begin
            r_s1_valid      <= bus.in_valid & ~w_illegal;
            r_s1_flush      <= bus.flush & ~w_illegal;
            r_s1_out        <= bus.out_en & ~w_illegal;
            r_s1_relu       <= bus.relu_en;
            r_s1_shift      <= bus.shift;
            bus.illegal_uop <= w_illegal;
            bus.out_valid_r <= w_emit;
            if (w_emit) begin
                bus.result_r <= w_res;
                bus.sat_r    <= w_sat;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DW-1:0]           w_x;
        logic [DW-1:0]           w_w;
        logic [2*DW-1:0]         w_prod;
        logic signed [ACC_W-1:0] r_term;
        logic signed [ACC_W-1:0] r_acc;
        logic signed [ACC_W-1:0] w_acc_next;
        logic signed [ACC_W-1:0] w_shifted;
        logic signed [ACC_W-1:0] w_relu;
        logic [DW-1:0]           w_clip;
        logic                    w_clip_hi;
        logic                    w_clip_lo;

        assign w_x = bus.x[l*DW +: DW];
        assign w_w = bus.weight[l*DW +: DW];
        // Low 2*DW bits of the sign-extended product equal the signed product.
        assign w_prod = {{DW{w_x[DW-1]}}, w_x} * {{DW{w_w[DW-1]}}, w_w};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_term <= '0;
            end else if (bus.in_valid) begin
                r_term <= bus.calc_bias ? {{(ACC_W-DW){w_w[DW-1]}}, w_w}
                                        : {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
            end
        end

        assign w_acc_next = r_s1_valid ? r_acc + r_term : r_acc;

        // Emitting clears the sum on the same edge so the next group starts at 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (r_s1_flush | w_emit) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end

        assign w_shifted = w_acc_next >>> r_s1_shift;
        assign w_relu    = (r_s1_relu & w_shifted[ACC_W-1]) ? '0 : w_shifted;
        assign w_clip_hi = w_relu > c_sat_max;
        assign w_clip_lo = w_relu < c_sat_min;
        assign w_clip    = w_clip_hi ? c_sat_max[DW-1:0]
                         : (w_clip_lo ? c_sat_min[DW-1:0] : w_relu[DW-1:0]);

        assign w_res[l*DW +: DW] = w_clip;
        assign w_sat[l]          = w_clip_hi | w_clip_lo;
    end
endmodule
`default_nettype wire

// File: tb/tb_pe_vec.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_vec
// Description : Directed vectors for pe_vec with a queued scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_vec;
    localparam int DW    = 16;
    localparam int LANES = 4;
    localparam int ACC_W = 40;
    localparam int SHW   = 6;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  sat;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc        = 0;
    int   vectors    = 0;
    int   miscompares = 0;
    int   ill_seen   = 0;
    int   ill_exp    = 0;
    exp_t sb[$];

    pe_vec_if #(.DW(DW), .LANES(LANES), .SHW(SHW)) u_if ();

    pe_vec #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] rep(input logic [15:0] v);
        return {4{v}};
    endfunction

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic set_uop(input logic iv, input logic fl, input logic oe, input logic cb,
                           input logic re, input logic [SHW-1:0] sh,
                           input logic [63:0] xv, input logic [63:0] wv);
        u_if.in_valid  = iv;
        u_if.flush     = fl;
        u_if.out_en    = oe;
        u_if.calc_bias = cb;
        u_if.relu_en   = re;
        u_if.shift     = sh;
        u_if.x         = xv;
        u_if.weight    = wv;
    endtask

    task automatic uop(input logic iv, input logic fl, input logic oe, input logic cb,
                       input logic re, input logic [SHW-1:0] sh,
                       input logic [63:0] xv, input logic [63:0] wv);
        set_uop(iv, fl, oe, cb, re, sh, xv, wv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) uop(0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
    endtask

    // Expected output lands one cycle after the edge that samples the next uop.
    task automatic expect_out(input logic [63:0] r, input logic [3:0] s);
        exp_t e;
        e.res = r;
        e.sat = s;
        e.cyc = cyc + 2;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (u_if.illegal_uop) ill_seen++;
        if (u_if.out_valid_r) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got out_valid_r=1 result %h, expected no output", u_if.result_r);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", u_if.result_r, e.res);
                chk("sat", {60'd0, u_if.sat_r}, {60'd0, e.sat});
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_uop(0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            set_uop(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    SHW'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge clk);
            chk("rst_result", u_if.result_r, 64'd0);
            chk("rst_sat", {60'd0, u_if.sat_r}, 64'd0);
            chk("rst_valid", {63'd0, u_if.out_valid_r}, 64'd0);
            chk("rst_illegal", {63'd0, u_if.illegal_uop}, 64'd0);
        end
        @(posedge clk);
        #1;
        set_uop(0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
        rst_n = 1'b1;
        idle(3);
        chk("idle_illegal", 64'(ill_seen), 64'd0);

        // 32 unit MACs then bias + emit, then a trailing flush
        for (int i = 0; i < 32; i++) uop(1, 0, 0, 0, 0, 0, rep(16'd1), rep(16'd1));
        expect_out(rep(16'd33), 4'h0);
        uop(1, 0, 1, 1, 0, 0, rep(16'd1), rep(16'd1));
        uop(0, 1, 0, 0, 0, 0, 64'd0, 64'd0);
        idle(3);
        chk("flush_illegal", 64'(ill_seen), 64'd0);

        uop(1, 0, 0, 0, 0, 0, rep(16'h7FFF), rep(16'h7FFF));
        uop(1, 0, 0, 0, 0, 0, rep(16'h7FFF), rep(16'h7FFF));
        expect_out(rep(16'h7FFF), 4'hF);
        uop(1, 0, 1, 0, 0, 0, 64'd0, 64'd0);
        idle(2);
        expect_out(rep(16'h8000), 4'hF);
        uop(1, 0, 1, 0, 0, 0, rep(16'h8000), rep(16'h7FFF));
        idle(2);
        expect_out(64'd0, 4'h0);
        uop(1, 0, 1, 0, 1, 0, rep(16'h8000), rep(16'h7FFF));
        idle(2);

        expect_out(pk(12, -13, 12, -13), 4'h0);
        uop(1, 0, 1, 0, 0, 3, pk(10, -10, 10, -10), rep(16'd10));
        idle(2);
        expect_out(pk(0, -1, 0, -1), 4'h0);
        uop(1, 0, 1, 0, 0, 45, pk(5, -5, 5, -5), rep(16'd1));
        expect_out(64'd0, 4'h0);
        uop(1, 0, 1, 0, 1, 63, pk(5, -5, 5, -5), rep(16'd1));
        idle(2);

        uop(1, 0, 0, 0, 0, 0, rep(16'd5), rep(16'd3));
        expect_out(rep(16'd29), 4'h0);
        uop(1, 0, 1, 0, 0, 0, rep(16'd7), rep(16'd2));
        idle(2);
        uop(1, 0, 0, 0, 0, 0, rep(16'd5), rep(16'd3));
        ill_exp++;
        uop(1, 1, 0, 0, 0, 0, rep(16'd100), rep(16'd100));
        ill_exp++;
        uop(0, 0, 0, 1, 0, 0, 64'd0, rep(16'd50));
        ill_exp++;
        uop(0, 0, 1, 0, 0, 0, rep(16'd1), rep(16'd1));
        expect_out(rep(16'd29), 4'h0);
        uop(1, 0, 1, 0, 0, 0, rep(16'd7), rep(16'd2));
        idle(3);
        chk("illegal_count", 64'(ill_seen), 64'(ill_exp));

        expect_out(rep(16'd6), 4'h0);
        uop(1, 0, 1, 0, 0, 0, rep(16'd2), rep(16'd3));
        expect_out(rep(16'd1), 4'h0);
        uop(1, 0, 1, 0, 0, 0, rep(16'd1), rep(16'd1));
        idle(3);

        // Reset with an emitting uop already in S1: it must vanish.
        uop(1, 0, 0, 0, 0, 0, rep(16'd9), rep(16'd9));
        uop(1, 0, 1, 0, 0, 0, rep(16'd9), rep(16'd9));
        set_uop(0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        chk("rst_mid_result", u_if.result_r, 64'd0);
        expect_out(rep(16'd16), 4'h0);
        uop(1, 0, 1, 0, 0, 0, rep(16'd4), rep(16'd4));
        idle(4);
        chk("hold_result", u_if.result_r, rep(16'd16));
        chk("illegal_final", 64'(ill_seen), 64'(ill_exp));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pe_vec.md
# pe_vec

Parametrised multi-lane successor to the scalar `pe` compute unit. Holds LANES independent signed multiply-accumulate lanes that share one micro-op control stream (`in_valid`, `flush`, `out_en`, `calc_bias`). Each lane accumulates x*weight products and optional bias terms in a wide accumulator. On output, each lane emits a shifted, optionally ReLU'd, saturated DW-bit result. The block sits in the NPU conv datapath between the operand fetch/broadcast logic and the output writeback buffer.

## Interface
- `DW`, default 16: signed operand and result width per lane.
- `LANES`, default 4: number of parallel MAC lanes.
- `ACC_W`, default 2*DW+8: signed accumulator width; must be ≥ 2*DW+1.
- `SHW`, default $clog2(ACC_W): width of the `shift` control.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `x` in LANES*DW: signed activations; lane l occupies bits [l*DW +: DW].
- `weight` in LANES*DW: signed weights, or the bias value when `calc_bias` is set; same packing as `x`.
- `in_valid` in 1: operand uop valid.
- `flush` in 1: clear-accumulator uop.
- `out_en` in 1: this is the final op of the group; emit the result.
- `calc_bias` in 1: add `weight` as the bias term instead of x*weight.
- `relu_en` in 1: clamp negative results to 0; sampled with the uop.
- `shift` in SHW: arithmetic right shift applied at output; sampled with the uop.
- `result_r` out LANES*DW: registered, saturated signed results.
- `out_valid_r` out 1: one-cycle pulse; `result_r` and `sat_r` are valid.
- `sat_r` out LANES: per-lane flag; the result was clipped by saturation.
- `illegal_uop` out 1: one-cycle pulse; an illegal control combination was dropped.

## Operation
- Legal uops on any edge:
  - idle: all controls low.
  - MAC: `in_valid`.
  - BIAS: `in_valid` & `calc_bias`.
  - Either MAC or BIAS with `out_en`.
  - FLUSH: `flush` alone.
- Illegal uops:
  - `flush` together with any other control.
  - `calc_bias` or `out_en` without `in_valid`.
- An illegal uop never enters the pipeline and has no effect on accumulators or outputs. `illegal_uop` is high for exactly the next cycle.
- Stage 1 (S1) registers, per lane:
  - term = sign-extended x*weight (full 2*DW product) for MAC, or sign-extended `weight` for BIAS, widened to ACC_W.
  - uop kind, `out_en`, `relu_en`, `shift`.
- Stage 2 (S2), per lane:
  - acc_next = acc + term. Two's-complement wraparound at ACC_W; no accumulator saturation.
  - FLUSH sets acc to 0.
  - If `out_en`: the result is computed from acc_next, and acc is cleared to 0 in the same edge, so the next group starts from 0.
- Output requantisation per lane:
  - v = acc_next >>> shift (arithmetic, floor).
  - If `relu_en` and v < 0, then v = 0.
  - Clip v to [-2^(DW-1), 2^(DW-1)-1].
  - `sat_r[l]` = 1 iff the clip changed v. A ReLU clamp alone does not set `sat_r`.
- Uops are processed strictly in order. FLUSH travels through S1 like any other uop, so a FLUSH issued right after an `out_en` op never corrupts that output.
- `result_r` and `sat_r` hold their last values until the next output; only `out_valid_r` pulses.

## Timing
- Reset (async assert, sync release use): acc, S1 valid/state, `result_r`, `sat_r`, `out_valid_r` and `illegal_uop` are all 0.
- Throughput: one uop per cycle, no stall, no backpressure.
- Latency: a uop sampled at edge N reaches S1 at edge N and updates acc at edge N+1. For an `out_en` uop, `out_valid_r` is high for the cycle after edge N+1.
- `illegal_uop` rises after edge N for an illegal combo sampled at N.
- Simultaneous events:
  - `out_en` at S2 and a new MAC at S1: the output uses the old group; the new MAC accumulates onto 0.
  - Consecutive `out_en` uops give consecutive `out_valid_r` pulses.
- Reset mid-group: all partial sums and in-flight uops are discarded; no `out_valid_r` pulse.
- `shift` ≥ ACC_W−1: the result is 0 or −1 by sign (then ReLU/clip rules apply).

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0; release, controls idle → no pulses.
- Group sum (DW=16, LANES=4): 32 cycles MAC with x=1, w=1, then MAC+BIAS+`out_en` with w=1, `shift`=0, then FLUSH → `out_valid_r` pulses 2 cycles after the final op; every lane=33, `sat_r`=0; FLUSH gives no pulse and `illegal_uop` stays 0.
- Saturation/ReLU:
  - Two MACs of 32767*32767, then `out_en` → lane=32767, `sat_r`=1.
  - x=−32768, w=32767 with `out_en` → −32768, `sat_r`=1.
  - Same with `relu_en`=1 → 0, `sat_r`=0.
- Shift: acc=100 (x=10, w=10), `shift`=3 → 12; acc=−100, `shift`=3 → −13.
- Illegal uops: `flush`+`in_valid`, or `calc_bias` alone, sampled mid-group → `illegal_uop` high one cycle; the final sum is unchanged versus the same stream without the illegal cycle.
- Back-to-back and reset:
  - MAC(x=2, w=3)+`out_en`, then MAC(x=1, w=1)+`out_en` next cycle → results 6 then 1 on consecutive cycles.
  - Assert `rst_n`=0 mid-group → no output; the next group starts from 0.
